mem_rotate_walker: RTL and testbench

//  Memory-walk rotate engine: reads NWORDS words starting at BASE_ADDR, spaced STRIDE bytes apart.

---
 rtl/mem_rotate_walker.sv | 180 ++++++++++++++++++
 tb/tb_mem_rotate_walker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rotate_walker.sv
// mem_rotate_walker
//
// Memory-walk rotate engine. It reads NWORDS words, starting at BASE_ADDR
// and spaced STRIDE bytes apart. Each word is rotated and written back to
// the same address. The whole walk is repeated PASSES times, then done rises.
//
// Optional feature: define CHECKSUM_EN to add a `checksum` output. It holds
// the XOR of every word written during the current run.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse; starts a run from IDLE or DONE
//   rot_left  1 = rotate left, 0 = rotate right (captured on accepted start)
//   rot_amt   rotate amount (captured on accepted start)
//   addr      registered memory byte address
//   rd_en     read request, held until rd_valid
//   rd_data   read data, valid with rd_valid
//   rd_valid  read completion; may coincide with the first rd_en cycle
//   wr_en     write strobe, one cycle per word
//   wr_data   registered rotated word
//   busy      high while reading or writing
//   done      high once all passes have completed
//   checksum  (CHECKSUM_EN only) running XOR of written words

module mem_rotate_walker #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned STRIDE    = 4,
    parameter int          NWORDS    = 5,
    parameter int          PASSES    = 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      rot_left,
    input  logic [$clog2(DATA_W)-1:0] rot_amt,
    output logic [ADDR_W-1:0]         addr,
    output logic                      rd_en,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      rd_valid,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy,
    output logic                      done
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]         checksum
`endif
);

    localparam int AMT_W  = $clog2(DATA_W);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int PCNT_W = $clog2(PASSES + 1);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(STRIDE);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
    localparam logic [PCNT_W-1:0] LAST_PASS = PCNT_W'(PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] word_cnt;
    logic [PCNT_W-1:0] pass_cnt;
    logic              rot_left_q;
    logic [AMT_W-1:0]  rot_amt_q;
    logic              last_word;
    logic              last_pass;

    // Rotating a doubled copy of the word gives a wrap-around rotate for any
    // amount, including zero, without any special cases.
    function automatic logic [DATA_W-1:0] rotate(
        input logic [DATA_W-1:0] x,
        input logic              left,
        input logic [AMT_W-1:0]  amt
    );
        logic [2*DATA_W-1:0] dbl;
        logic [DATA_W-1:0]   res;
        dbl = {x, x};
        if (left) begin
            dbl = dbl << amt;
            res = dbl[2*DATA_W-1:DATA_W];
        end else begin
            dbl = dbl >> amt;
            res = dbl[DATA_W-1:0];
        end
        return res;
    endfunction

    assign last_word = (word_cnt == LAST_WORD);
    assign last_pass = (pass_cnt == LAST_PASS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RD;
            S_RD:    if (rd_valid) state_next = S_WR;
            S_WR:    state_next = (last_word && last_pass) ? S_DONE : S_RD;
            S_DONE:  if (start) state_next = S_RD;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: the rotate settings are captured on start, so later changes
    // to rot_* do not affect a run in progress. The address wraps to BASE at
    // the end of every pass, which also leaves it at BASE in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= BASE;
            wr_data    <= '0;
            word_cnt   <= '0;
            pass_cnt   <= '0;
            rot_left_q <= 1'b0;
            rot_amt_q  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr       <= BASE;
                        word_cnt   <= '0;
                        pass_cnt   <= '0;
                        rot_left_q <= rot_left;
                        rot_amt_q  <= rot_amt;
                    end
                end
                S_RD: begin
                    if (rd_valid) begin
                        wr_data <= rotate(rd_data, rot_left_q, rot_amt_q);
                    end
                end
                S_WR: begin
                    if (last_word) begin
                        addr     <= BASE;
                        word_cnt <= '0;
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        addr     <= addr + STEP;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // XOR of every word written since the last accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == S_IDLE || state == S_DONE) && start) begin
            checksum <= '0;
        end else if (state == S_WR) begin
            checksum <= checksum ^ wr_data;
        end
    end
`endif

    assign rd_en = (state == S_RD);
    assign wr_en = (state == S_WR);
    assign busy  = (state == S_RD) || (state == S_WR);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_mem_rotate_walker.sv
// tb_mem_rotate_walker
//
// Self-checking bench for mem_rotate_walker (NWORDS=5, PASSES=2). A small
// memory model answers reads with a programmable latency and applies writes.
// A reference model predicts the exact write sequence of each run. It does
// this by rotating the memory image one bit at a time.

module tb_mem_rotate_walker;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int BASE_ADDR = 0;
    localparam int STRIDE    = 4;
    localparam int NWORDS    = 5;
    localparam int PASSES    = 2;
    localparam int AMT_W     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rot_left;
    logic [AMT_W-1:0]  rot_amt;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    mem_rotate_walker #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .STRIDE   (STRIDE),
        .NWORDS   (NWORDS),
        .PASSES   (PASSES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rot_left(rot_left),
        .rot_amt (rot_amt),
        .addr    (addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
`ifdef CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [NWORDS];
    wr_t         exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          lat          = 0;
    int          wait_cnt     = 0;
    bit          noise_en     = 1'b0;
    logic        noise        = 1'b0;
    int          write_count  = 0;
    logic        prev_wr      = 1'b0;
    logic        prev_rd      = 1'b0;
    int          rd_len       = 0;
    logic [31:0] first_data   = '0;
    logic [31:0] exp_csum     = '0;

    function automatic int word_index(input logic [31:0] a);
        logic [31:0] i;
        i = (a - 32'(BASE_ADDR)) / 32'(STRIDE);
        return (i < 32'(NWORDS)) ? int'(i) : 0;
    endfunction

    function automatic logic [31:0] model_rot(input logic [31:0] x, input bit left, input int amt);
        logic [31:0] r;
        r = x;
        for (int k = 0; k < amt; k++) begin
            r = left ? {r[30:0], r[31]} : {r[0], r[31:1]};
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Memory side: zero-wait when lat==0, otherwise rd_valid after lat extra
    // cycles. Outside reads rd_valid carries random noise.
    assign rd_data  = mem[word_index(addr)];
    assign rd_valid = rd_en ? (wait_cnt >= lat) : noise;

    always @(posedge clk) begin
        wait_cnt <= (rd_en && !rd_valid) ? wait_cnt + 1 : 0;
    end

    // Monitor: checks every write against the predicted sequence, applies it
    // to memory, and checks that each read request lasts lat+1 cycles.
    always @(negedge clk) begin
        wr_t e;
        noise = noise_en ? 1'($urandom) : 1'b0;
        if (rst) begin
            prev_wr = 1'b0;
            prev_rd = 1'b0;
            rd_len  = 0;
        end else begin
            if (rd_en) begin
                rd_len++;
            end else if (prev_rd) begin
                checkOutput("rd_en_len", 64'(rd_len), 64'(lat + 1));
                rd_len = 0;
            end
            if (wr_en) begin
                checkOutput("wr_en_single", 64'(prev_wr), 64'(0));
                checkOutput("busy_in_wr", 64'(busy), 64'(1));
                if (write_count == 0) first_data = wr_data;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", 64'(addr), 64'(e.a));
                    checkOutput("wr_data", 64'(wr_data), 64'(e.d));
                end
                mem[word_index(addr)] = wr_data;
                write_count++;
            end
            prev_wr = wr_en;
            prev_rd = rd_en;
        end
    end

    task automatic build_model(input bit left, input int amt);
        logic [31:0] m [NWORDS];
        for (int w = 0; w < NWORDS; w++) m[w] = mem[w];
        exp_q.delete();
        exp_csum = '0;
        for (int p = 0; p < PASSES; p++) begin
            for (int w = 0; w < NWORDS; w++) begin
                m[w] = model_rot(m[w], left, amt);
                exp_q.push_back('{a: 32'(BASE_ADDR + w * STRIDE), d: m[w]});
                exp_csum ^= m[w];
            end
        end
    endtask

    task automatic pulse_start(input bit left, input int amt);
        @(negedge clk);
        #1;
        start    = 1'b1;
        rot_left = left;
        rot_amt  = AMT_W'(amt);
        @(negedge clk);
        #1;
        start    = 1'b0;
        rot_left = 1'($urandom);
        rot_amt  = AMT_W'($urandom);
    endtask

    // One complete run, checked from start to DONE.
    task automatic applyStimulus(input bit left, input int amt, input int latency, input bit poke_busy);
        int cycles;
        int saved;
        build_model(left, amt);
        lat         = latency;
        write_count = 0;
        pulse_start(left, amt);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(negedge clk);
            #1;
            cycles++;
            if (poke_busy && cycles == 7) begin
                start    = 1'b1;
                rot_left = ~left;
                rot_amt  = AMT_W'(amt + 3);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("done_reached", 64'(done), 64'(1));
        checkOutput("busy_in_done", 64'(busy), 64'(0));
        checkOutput("addr_in_done", 64'(addr), 64'(BASE_ADDR));
        checkOutput("write_total", 64'(write_count), 64'(NWORDS * PASSES));
        checkOutput("writes_left", 64'(exp_q.size()), 64'(0));
`ifdef CHECKSUM_EN
        checkOutput("checksum", 64'(checksum), 64'(exp_csum));
`endif
        saved = write_count;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("done_held", 64'(done), 64'(1));
        checkOutput("no_write_in_done", 64'(write_count), 64'(saved));
    endtask

    initial begin
        int cycles;
        int saved;
        rst      = 1'b1;
        start    = 1'b0;
        rot_left = 1'b0;
        rot_amt  = '0;
        for (int w = 0; w < NWORDS; w++) mem[w] = 32'h8000_0001;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_addr", 64'(addr), 64'(BASE_ADDR));
        checkOutput("rst_wr_data", 64'(wr_data), 64'(0));
        checkOutput("rst_ctrl", 64'({rd_en, wr_en, busy, done}), 64'(0));
`ifdef CHECKSUM_EN
        checkOutput("rst_checksum", 64'(checksum), 64'(0));
`endif
        rst = 1'b0;

        // Rotate left by one over two passes, zero-wait reads
        applyStimulus(1'b1, 1, 0, 1'b0);
        checkOutput("t1_pass1_data", 64'(first_data), 64'(32'h0000_0003));
        checkOutput("t1_pass2_data", 64'(mem[0]), 64'(32'h0000_0006));

        // Rotate right by four; then amount zero (run from DONE)
        for (int w = 0; w < NWORDS; w++) mem[w] = 32'h1234_5678;
        applyStimulus(1'b0, 4, 0, 1'b0);
        checkOutput("t2_rot_right4", 64'(first_data), 64'(32'h8123_4567));
        for (int w = 0; w < NWORDS; w++) mem[w] = 32'h1234_5678;
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("t2_rot_zero", 64'(first_data), 64'(32'h1234_5678));

        // Three-cycle read latency, noise on rd_valid, start poked while busy
        noise_en = 1'b1;
        applyStimulus(1'b1, 7, 3, 1'b1);

        // Checksum pattern {1,2,4,8,16} rotated left by one, two passes
        for (int w = 0; w < NWORDS; w++) mem[w] = 32'(1) << w;
        applyStimulus(1'b1, 1, 0, 1'b0);
`ifdef CHECKSUM_EN
        checkOutput("t6_checksum", 64'(checksum), 64'(32'h0000_0042));
`endif

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
            applyStimulus(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                          1'($urandom));
        end

        // Reset during the write of word 2 aborts the run
        noise_en = 1'b0;
        for (int w = 0; w < NWORDS; w++) mem[w] = $urandom;
        build_model(1'b1, 5);
        lat         = 0;
        write_count = 0;
        pulse_start(1'b1, 5);
        cycles = 0;
        while (!(wr_en && addr == 32'(BASE_ADDR + 2 * STRIDE)) && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("t5_reached_word2", 64'(wr_en), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t5_wr_en", 64'(wr_en), 64'(0));
        checkOutput("t5_addr", 64'(addr), 64'(BASE_ADDR));
        checkOutput("t5_idle", 64'({rd_en, busy, done}), 64'(0));
        checkOutput("t5_writes", 64'(write_count), 64'(3));
        exp_q.delete();
        saved = write_count;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("t5_no_more_writes", 64'(write_count), 64'(saved));
        checkOutput("t5_still_idle", 64'(busy), 64'(0));

        // A fresh start after the abort works normally
        applyStimulus(1'b0, 13, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
